control_multicycle_fsm: RTL
===========================

# control_multicycle_fsm

Multicycle control unit for the processor: replaces single-cycle decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB controller. It generates datapath control fields and per-state write strobes, and handshakes with the instruction and data memories, which may insert wait states. A programmable timeout traps hung memory accesses into a sticky FAULT state. The block sits between the instruction register and the datapath/memory interfaces.

## Interface
- TIMEOUT_W, default 8: width of the memory wait counter.
- TIMEOUT, default 255: wait cycles without ready before FAULT; must be nonzero and no greater than 2^TIMEOUT_W-1.
- CNT_W, default 32: width of the performance counters.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  2  instruction class from IR.
- funct5  in  1  op=01: 0 = store, 1 = load.
- funct0  in  1  op=10: 1 = branch.
- cond_true  in  1  branch condition from flags, sampled in EXEC.
- imem_ready, dmem_ready  in  1 each  memory access complete.
- imem_req, dmem_req, dmem_we  out  1 each  memory requests.
- ir_we, pc_we, pc_src  out  1 each  IR load, PC load, PC source (0 = PC+4, 1 = branch target).
- regw, memw, memtoreg, alusrc, aluop  out  1 each  datapath controls.
- immsrc, regsrc  out  2 each  immediate and register-source select.
- fault  out  1  sticky timeout flag.
- state  out  3  current state, for debug.
- cycle_cnt, instr_cnt  out  CNT_W each  present only with CTRL_PERF_CNT_EN.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset state is FETCH.
- FETCH: imem_req=1. On imem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: one cycle. op, funct5 and funct0 are stable from here through the end of the instruction. Go to EXEC.
- EXEC:
  - Branch (op=10, funct0=1): pc_we=cond_true, pc_src=1, then go to FETCH. No register write.
  - op=01: go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1, dmem_we=memw=~funct5. On dmem_ready, a store goes to FETCH and a load goes to WB.
- WB: regw=1 for one cycle, memtoreg=(op==01). Go to FETCH.
- Field decode is combinational from op in DECODE..WB and all-zero in FETCH and FAULT:
  - alusrc=~op[1]
  - immsrc=op
  - regsrc=op
  - aluop=op[1]
- Wait counter:
  - Cleared on entry to FETCH or MEM and on every ready.
  - Increments each cycle a request is outstanding without ready.
  - Reaching TIMEOUT without ready moves the FSM to FAULT.
  - Ready in the same cycle the counter hits TIMEOUT takes priority: normal transition.
- FAULT: all requests and strobes are 0 and fault=1. The FSM stays in FAULT until rst.
- Strobes are Moore outputs decoded from the state register; there are no extra output flops.

## Timing
- Reset: while rst is high and on the following edge, all outputs are 0, counters are 0, and state is FETCH.
- The first imem_req occurs in the cycle after rst deasserts.
- Ready asserted in the first request cycle gives a zero-wait access (the state lasts 1 cycle).
- Zero-wait latencies, in cycles per instruction:
  - ALU: 4
  - store: 4
  - load: 5
  - branch: 3
- Each memory wait cycle adds 1 cycle to the instruction.
- rst asserted mid-instruction aborts it. Nothing is retired, and no strobe fires in the rst cycle.
- cond_true is sampled only in EXEC.

## Configuration
- CTRL_PERF_CNT_EN defined: cycle_cnt and instr_cnt ports exist.
  - cycle_cnt increments every non-reset cycle outside FAULT.
  - instr_cnt increments on the last cycle of each instruction: branch EXEC, store MEM with ready, or WB.
  - Both counters wrap modulo 2^CNT_W and freeze in FAULT.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Package ctrl_pkg holds:
  - the state enum, with FETCH=0
  - op class constants: OP_ALUI=2'b00, OP_MEM=2'b01, OP_ALUR=2'b10, OP_ALUR2=2'b11
- Sub-module ctrl_field_decoder: combinational op → alusrc, immsrc, regsrc, aluop, gated by a valid input from the FSM.

## Test plan
- Reset, then an op=00 instruction with ready held high → state sequence FETCH, DECODE, EXEC, WB, FETCH over 4 cycles; regw=1 in WB only; alusrc=1, immsrc=00.
- Load (op=01, funct5=1) with dmem_ready delayed 3 cycles → MEM lasts 4 cycles, dmem_we=0, then WB with memtoreg=1; total 8 cycles.
- Branch (op=10, funct0=1) with cond_true=1, then with 0 → pc_we=1, pc_src=1 in EXEC for the first; pc_we=0 for the second; regw never asserted.
- imem_ready held low with TIMEOUT=4 → FAULT after 4 wait cycles, fault=1, all requests 0; stays in FAULT until rst. Repeat with ready arriving exactly at the 4th cycle → no fault.
- rst asserted during MEM of a store → no memw on that edge, FETCH after reset, instr_cnt=0.
- With CTRL_PERF_CNT_EN, 3 back-to-back zero-wait ALU instructions → instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit:
//   - state_e   : FSM state encoding (FETCH = 0, reported on the debug port)
//   - OP_*      : instruction class codes carried on the op field
//   - is_branch : branch recognition used by the FSM
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_e;

  localparam logic [1:0] OP_ALUI  = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_ALUR  = 2'b10;
  localparam logic [1:0] OP_ALUR2 = 2'b11;

  // Only the OP_ALUR class doubles as a branch, selected by funct0.
  function automatic logic is_branch(input logic [1:0] op, input logic funct0);
    return (op == OP_ALUR) && funct0;
  endfunction

endpackage

// File: rtl/ctrl_field_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_field_decoder
// Combinational decode of the instruction class into datapath select fields.
// All outputs are forced to zero while valid is low, so the datapath sees
// quiet selects outside the DECODE..WB window.
// Ports:
//   valid  in  1  FSM is in DECODE, EXEC, MEM or WB (and not in reset)
//   op     in  2  instruction class
//   alusrc out 1  ALU B operand: 1 = immediate
//   immsrc out 2  immediate format select
//   regsrc out 2  register-source select
//   aluop  out 1  ALU operation group
// ---------------------------------------------------------------------------
module ctrl_field_decoder
  import ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [1:0] op,
  output logic       alusrc,
  output logic [1:0] immsrc,
  output logic [1:0] regsrc,
  output logic       aluop
);

  // NOTE: every output gets a default before any condition, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    alusrc = 1'b0;
    immsrc = 2'b00;
    regsrc = 2'b00;
    aluop  = 1'b0;
    if (valid) begin
      // Register-register classes (OP_ALUR, OP_ALUR2) have op[1] set.
      alusrc = ~op[1];
      immsrc = op;
      regsrc = op;
      aluop  = op[1];
    end
  end

endmodule

// File: rtl/control_multicycle_fsm.sv
// ---------------------------------------------------------------------------
// control_multicycle_fsm
// Sequenced FETCH/DECODE/EXEC/MEM/WB controller. Handshakes with instruction
// and data memories that may insert wait states; a wait counter traps a hung
// access into a sticky FAULT state that only rst leaves.
// All strobes are decoded from the state register (plus the ready/condition
// inputs of the current state) and forced low while rst is high.
//
// Parameters:
//   TIMEOUT_W  width of the memory wait counter
//   TIMEOUT    wait cycles without ready before FAULT (1 .. 2^TIMEOUT_W-1)
//   CNT_W      width of the performance counters
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op, funct5, funct0        instruction class and sub-function bits
//   cond_true                 branch condition, used only in EXEC
//   imem_ready, dmem_ready    memory access complete
//   imem_req, dmem_req, dmem_we  memory requests
//   ir_we, pc_we, pc_src      IR load, PC load, PC source (1 = branch target)
//   regw, memw, memtoreg, alusrc, aluop, immsrc, regsrc  datapath controls
//   fault                     sticky timeout flag
//   state                     current state for debug
//   cycle_cnt, instr_cnt      performance counters (CTRL_PERF_CNT_EN only)
// Build option: define CTRL_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module control_multicycle_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             funct5,
  input  logic             funct0,
  input  logic             cond_true,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             regw,
  output logic             memw,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             aluop,
  output logic [1:0]       immsrc,
  output logic [1:0]       regsrc,
  output logic             fault,
  output logic [2:0]       state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  if (TIMEOUT < 1 || longint'(TIMEOUT) > ((longint'(1) << TIMEOUT_W) - 1)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1 .. 2^TIMEOUT_W-1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  // The access faults in the cycle whose miss would take the count to TIMEOUT.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q,  wait_d;
  logic                 timeout_hit;
  logic                 active;

  assign timeout_hit = (wait_q == WAIT_LAST);
  assign active      = ~rst;

  // Next state and wait counter. The counter is zero in every state except
  // while a request is waiting, which clears it on entry to FETCH/MEM and
  // on every ready.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      FETCH: begin
        if (imem_ready)       state_d = DECODE;
        else if (timeout_hit) state_d = FAULT;
        else                  wait_d  = wait_q + 1'b1;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_branch(op, funct0)) state_d = FETCH;
        else if (op == OP_MEM)     state_d = MEM;
        else                       state_d = WB;
      end
      MEM: begin
        if (dmem_ready)       state_d = funct5 ? WB : FETCH;
        else if (timeout_hit) state_d = FAULT;
        else                  wait_d  = wait_q + 1'b1;
      end
      WB:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the processes run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Moore strobes, silenced during rst so an aborted instruction fires nothing.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    regw     = 1'b0;
    memw     = 1'b0;
    memtoreg = 1'b0;
    fault    = 1'b0;
    if (active) begin
      unique case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
          pc_we    = imem_ready;
        end
        EXEC: begin
          if (is_branch(op, funct0)) begin
            pc_we  = cond_true;
            pc_src = 1'b1;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = ~funct5;
          memw     = ~funct5;
        end
        WB: begin
          regw     = 1'b1;
          memtoreg = (op == OP_MEM);
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = active ? state_q : FETCH;

  logic fields_valid;
  assign fields_valid = active && (state_q inside {DECODE, EXEC, MEM, WB});

  ctrl_field_decoder u_field_decoder (
    .valid  (fields_valid),
    .op     (op),
    .alusrc (alusrc),
    .immsrc (immsrc),
    .regsrc (regsrc),
    .aluop  (aluop)
  );

`ifdef CTRL_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  // Last cycle of an instruction: branch EXEC, completed store, or WB.
  assign retire = active &&
                  (((state_q == EXEC) && is_branch(op, funct0)) ||
                   ((state_q == MEM) && dmem_ready && ~funct5) ||
                   (state_q == WB));

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (state_q != FAULT) begin
      cycle_d = cycle_q + 1'b1;
      if (retire) instr_d = instr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt = active ? cycle_q : '0;
  assign instr_cnt = active ? instr_q : '0;
`endif

endmodule
